ysyx_22041071_wb_arb: RTL and testbench

- Writeback arbiter/scheduler owning the single integer register-file write port.
- Shares the port between two requesters: the in-order pipeline WB stage and the long-latency multiply/divide unit (MDU).
- Grants one requester per cycle with a starvation guard, then registers the winner onto the regfile write port and the commit/difftest interface.

---
 rtl/ysyx_22041071_wb_arb.sv | 102 ++++++++++
 tb/tb_ysyx_22041071_wb_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_wb_arb.sv
// Writeback arbiter: shares the single regfile write port between the in-order
// pipeline WB stage and the MDU, with a bounded-starvation guard for the pipeline.
module ysyx_22041071_wb_arb #(
   parameter int ADDR_W     = 64,
   parameter int INS_W      = 32,
   parameter int DATA_W     = 64,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_valid,
   output logic              p_ready,
   input  logic [ADDR_W-1:0] p_pc,
   input  logic [INS_W-1:0]  p_ins,
   input  logic              p_wen,
   input  logic [4:0]        p_rd,
   input  logic [DATA_W-1:0] p_data,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [ADDR_W-1:0] m_pc,
   input  logic [INS_W-1:0]  m_ins,
   input  logic [4:0]        m_rd,
   input  logic [DATA_W-1:0] m_data,
   output logic              rf_wen,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              cmt_valid,
   output logic [ADDR_W-1:0] cmt_pc,
   output logic [INS_W-1:0]  cmt_ins,
   output logic              cmt_src,
   output logic [2:0]        starve_cnt
);

   localparam logic [2:0] LIM = 3'(STARVE_LIM);

   logic       grant_p;
   logic       grant_m;
   logic [2:0] cnt_next;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v >= LIM) ? LIM : v + 3'd1;
   endfunction

   // MDU wins ties until the pipeline has waited STARVE_LIM consecutive grants.
   always_comb begin
      grant_p = 1'b0;
      grant_m = 1'b0;
      if (reset) begin
         if (p_valid && m_valid) begin
            if (starve_cnt >= LIM) grant_p = 1'b1;
            else                   grant_m = 1'b1;
         end else if (p_valid) begin
            grant_p = 1'b1;
         end else if (m_valid) begin
            grant_m = 1'b1;
         end
      end
   end

   assign p_ready = grant_p;
   assign m_ready = grant_m;

   always_comb begin
      cnt_next = 3'd0;
      if (grant_m && p_valid) cnt_next = sat_inc(starve_cnt);
   end

   // Commit stage: winner registered onto regfile/commit ports; payload holds when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 3'd0;
         rf_wen     <= 1'b0;
         rf_waddr   <= 5'd0;
         rf_wdata   <= '0;
         cmt_valid  <= 1'b0;
         cmt_pc     <= '0;
         cmt_ins    <= '0;
         cmt_src    <= 1'b0;
      end else begin
         starve_cnt <= cnt_next;
         cmt_valid  <= grant_p | grant_m;
         if (grant_p) begin
            rf_wen   <= p_wen && (p_rd != 5'd0);
            rf_waddr <= p_rd;
            rf_wdata <= p_data;
            cmt_pc   <= p_pc;
            cmt_ins  <= p_ins;
            cmt_src  <= 1'b0;
         end else if (grant_m) begin
            rf_wen   <= (m_rd != 5'd0);
            rf_waddr <= m_rd;
            rf_wdata <= m_data;
            cmt_pc   <= m_pc;
            cmt_ins  <= m_ins;
            cmt_src  <= 1'b1;
         end else begin
            rf_wen   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_wb_arb.sv
// Bench for ysyx_22041071_wb_arb: directed scenarios plus constrained-random
// traffic compared against a behavioural model of the grant/commit rules.
module tb_ysyx_22041071_wb_arb;

   localparam int ADDR_W = 64;
   localparam int INS_W  = 32;
   localparam int DATA_W = 64;
   localparam int LIM    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              p_valid, p_ready, p_wen;
   logic [ADDR_W-1:0] p_pc;
   logic [INS_W-1:0]  p_ins;
   logic [4:0]        p_rd;
   logic [DATA_W-1:0] p_data;
   logic              m_valid, m_ready;
   logic [ADDR_W-1:0] m_pc;
   logic [INS_W-1:0]  m_ins;
   logic [4:0]        m_rd;
   logic [DATA_W-1:0] m_data;
   logic              rf_wen, cmt_valid, cmt_src;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [ADDR_W-1:0] cmt_pc;
   logic [INS_W-1:0]  cmt_ins;
   logic [2:0]        starve_cnt;

   always #5 clk = ~clk;

   ysyx_22041071_wb_arb #(
      .ADDR_W(ADDR_W), .INS_W(INS_W), .DATA_W(DATA_W), .STARVE_LIM(LIM)
   ) dut (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_ready(p_ready), .p_pc(p_pc), .p_ins(p_ins),
      .p_wen(p_wen), .p_rd(p_rd), .p_data(p_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_ins(m_ins),
      .m_rd(m_rd), .m_data(m_data),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ins(cmt_ins),
      .cmt_src(cmt_src), .starve_cnt(starve_cnt)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Behavioural model: who wins this cycle, and what the commit ports show next.
   int              waited;   // consecutive MDU wins while pipeline waited
   int              winner;   // 0 none, 1 pipeline, 2 MDU
   logic            e_wen, e_valid, e_src;
   logic [4:0]      e_waddr;
   logic [63:0]     e_wdata, e_pc;
   logic [31:0]     e_ins;

   task automatic model_reset();
      waited = 0; winner = 0;
      e_wen = 0; e_valid = 0; e_src = 0; e_waddr = 0; e_wdata = 0; e_pc = 0; e_ins = 0;
   endtask

   task automatic predict();
      if (p_valid && m_valid) winner = (waited >= LIM) ? 1 : 2;
      else if (p_valid)       winner = 1;
      else if (m_valid)       winner = 2;
      else                    winner = 0;
   endtask

   task automatic commit();
      if (winner == 1) begin
         e_valid = 1; e_src = 0; e_wen = p_wen && (p_rd != 0);
         e_waddr = p_rd; e_wdata = p_data; e_pc = p_pc; e_ins = p_ins;
         waited = 0;
      end else if (winner == 2) begin
         e_valid = 1; e_src = 1; e_wen = (m_rd != 0);
         e_waddr = m_rd; e_wdata = m_data; e_pc = m_pc; e_ins = m_ins;
         waited = p_valid ? ((waited + 1 > LIM) ? LIM : waited + 1) : 0;
      end else begin
         e_valid = 0; e_wen = 0; waited = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_rf_wen"},   rf_wen,    e_wen);
      check({tag, "_rf_waddr"}, rf_waddr,  e_waddr);
      check({tag, "_rf_wdata"}, rf_wdata,  e_wdata);
      check({tag, "_cmt_valid"},cmt_valid, e_valid);
      check({tag, "_cmt_pc"},   cmt_pc,    e_pc);
      check({tag, "_cmt_ins"},  cmt_ins,   e_ins);
      check({tag, "_cmt_src"},  cmt_src,   e_src);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_p_ready"}, p_ready, 0);
      check({tag, "_m_ready"}, m_ready, 0);
      check({tag, "_rf_wen"},  rf_wen, 0);
      check({tag, "_rf_waddr"},rf_waddr, 0);
      check({tag, "_rf_wdata"},rf_wdata, 0);
      check({tag, "_cmt_valid"},cmt_valid, 0);
      check({tag, "_cmt_pc"},  cmt_pc, 0);
      check({tag, "_cmt_ins"}, cmt_ins, 0);
      check({tag, "_cmt_src"}, cmt_src, 0);
      check({tag, "_starve"},  starve_cnt, 0);
   endtask

   // Inputs are already applied; check handshake, clock, then check commit ports.
   task automatic cycle(input string tag);
      #1;
      predict();
      check({tag, "_p_ready"}, p_ready, winner == 1);
      check({tag, "_m_ready"}, m_ready, winner == 2);
      check({tag, "_starve"},  starve_cnt, waited);
      @(posedge clk);
      #1;
      commit();
      check_outputs(tag);
   endtask

   task automatic rand_p();
      p_valid = ($urandom_range(0, 3) != 0);
      p_wen   = ($urandom_range(0, 3) != 0);
      p_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      p_pc    = {$urandom, $urandom};
      p_ins   = $urandom;
      p_data  = {$urandom, $urandom};
   endtask

   task automatic rand_m();
      m_valid = ($urandom_range(0, 2) == 0);
      m_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      m_pc    = {$urandom, $urandom};
      m_ins   = $urandom;
      m_data  = {$urandom, $urandom};
   endtask

   int cnt_tab[6]   = '{0, 1, 2, 3, 4, 0};
   int mgrant_tab[6] = '{1, 1, 1, 1, 0, 1};

   initial begin
      model_reset();
      reset = 1'b0;
      rand_p(); rand_m();
      p_valid = 1; m_valid = 1;
      #22;
      check_all_zero("reset");

      // Release reset with a pipeline write pending.
      @(negedge clk);
      reset = 1'b1;
      m_valid = 0; p_valid = 1; p_rd = 5; p_data = 64'h11; p_wen = 1;
      cycle("rel");
      check("rel_waddr_const", rf_waddr, 5);
      check("rel_src_const", cmt_src, 0);

      // MDU only.
      p_valid = 0;
      m_valid = 1; m_rd = 7; m_data = 64'hDEAD; m_pc = 64'h8000_0010;
      cycle("mdu");
      check("mdu_pc_const", cmt_pc, 64'h8000_0010);
      check("mdu_src_const", cmt_src, 1);

      // Starvation guard with both requesters held valid.
      p_valid = 1; p_wen = 1; p_rd = 9; p_data = 64'hAAAA;
      m_valid = 1; m_rd = 10; m_data = 64'hBBBB;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("stv_cnt_tab", starve_cnt, cnt_tab[i]);
         check("stv_mgrant_tab", m_ready, mgrant_tab[i]);
         cycle("stv");
      end

      // x0 write is suppressed but still commits.
      m_valid = 0;
      p_valid = 1; p_wen = 1; p_rd = 0; p_ins = 32'h0000_0013;
      cycle("x0");
      check("x0_wen_const", rf_wen, 0);
      check("x0_ins_const", cmt_ins, 32'h13);

      // Idle cycles hold payload; then a non-writing pipeline commit.
      p_valid = 0; m_valid = 0;
      cycle("idle0");
      cycle("idle1");
      p_valid = 1; p_wen = 0; p_rd = 3;
      cycle("nowr");
      check("nowr_wen_const", rf_wen, 0);

      // Random traffic; a requester changes payload only after acceptance or when idle.
      winner = 0;
      rand_p(); rand_m();
      for (int i = 0; i < 400; i++) begin
         cycle("rnd");
         if (!p_valid || winner == 1) rand_p();
         if (!m_valid || winner == 2) rand_m();
      end

      // Asynchronous reset between edges while a grant is pending.
      p_valid = 1; p_data = 64'h1234; p_rd = 4; p_wen = 1;
      m_valid = 1; m_data = 64'h5678; m_rd = 6;
      cycle("pre_arst");
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("arst");
      @(posedge clk);
      #1;
      check_all_zero("arst_hold");
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      cycle("post_arst");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
